// File: rtl/modulation_branch_select_pipe.sv
// If/else select stage: picks the then- or else-operand from an unsigned compare and
// returns it LATENCY cycles after start, either one op at a time (FSM) or fully pipelined.
module modulation_branch_select_pipe #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 2,
  parameter int PIPELINED = 0,
  parameter int INVERT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_bit,
  input  logic [WIDTH-1:0] zero,
  input  logic [WIDTH-1:0] array_ref_wire,
  input  logic [WIDTH-1:0] array_ref_m_wire,
  output logic [WIDTH-1:0] segment,
  output logic             branch_taken,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  logic             cond;
  logic [WIDTH-1:0] sel;

  assign cond = (input_bit != zero) ^ (INVERT != 0);
  assign sel  = cond ? array_ref_wire : array_ref_m_wire;

  if (PIPELINED != 0) begin : g_pipe
    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] pc;
    logic [WIDTH-1:0]   ps [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pv           <= '0;
        pc           <= '0;
        for (int i = 0; i < LATENCY; i++) ps[i] <= '0;
        segment      <= '0;
        branch_taken <= 1'b0;
        valid        <= 1'b0;
      end else begin
        pv[0] <= start;
        pc[0] <= cond;
        ps[0] <= sel;
        for (int i = 1; i < LATENCY; i++) begin
          pv[i] <= pv[i-1];
          pc[i] <= pc[i-1];
          ps[i] <= ps[i-1];
        end
        valid <= pv[LATENCY-1];
        if (pv[LATENCY-1]) begin
          segment      <= ps[LATENCY-1];
          branch_taken <= pc[LATENCY-1];
        end
      end
    end

    assign busy    = |pv;
    assign overrun = 1'b0;

  end else begin : g_fsm
    // state | meaning
    // IDLE  | no op in flight
    // RUN   | op captured, counting down to completion
    // DONE  | result presented this cycle (valid high)
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             cap_cond;
    logic [WIDTH-1:0] cap_sel;
    logic             completing;
    logic             accept;

    assign completing = (state == RUN) && (cnt == 4'd0);
    // A start on the completion edge is taken alongside the finishing op.
    assign accept     = start && ((state != RUN) || completing);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state        <= IDLE;
        cnt          <= '0;
        cap_cond     <= 1'b0;
        cap_sel      <= '0;
        segment      <= '0;
        branch_taken <= 1'b0;
        valid        <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        valid <= 1'b0;
        if (state == RUN) begin
          if (cnt == 4'd0) begin
            valid        <= 1'b1;
            segment      <= cap_sel;
            branch_taken <= cap_cond;
            state        <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end else if (state == DONE) begin
          state <= IDLE;
        end
        if (accept) begin
          cap_cond <= cond;
          cap_sel  <= sel;
          cnt      <= CNT_LOAD;
          state    <= RUN;
        end
        if (start && !accept) overrun <= 1'b1;
      end
    end

    assign busy = (state == RUN);
  end

endmodule

// File: tb/tb_modulation_branch_select_pipe.sv
// Directed bench: four configurations (single-issue L=2, inverted L=2, pipelined L=3,
// single-issue L=1) sharing data inputs, each with its own start.
module tb_modulation_branch_select_pipe;
  logic clk, reset;
  logic [31:0] ib, z, w, m;
  logic start_a, start_i, start_p, start_1;
  logic [31:0] seg_a, seg_i, seg_p, seg_1;
  logic bt_a, bt_i, bt_p, bt_1;
  logic v_a, v_i, v_p, v_1;
  logic b_a, b_i, b_p, b_1;
  logic o_a, o_i, o_p, o_1;
  int n_checks = 0;
  int n_errors = 0;

  modulation_branch_select_pipe #(.WIDTH(32), .LATENCY(2), .PIPELINED(0), .INVERT(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .input_bit(ib), .zero(z),
    .array_ref_wire(w), .array_ref_m_wire(m), .segment(seg_a), .branch_taken(bt_a),
    .valid(v_a), .busy(b_a), .overrun(o_a));
  modulation_branch_select_pipe #(.WIDTH(32), .LATENCY(2), .PIPELINED(0), .INVERT(1)) dut_i (
    .clk(clk), .reset(reset), .start(start_i), .input_bit(ib), .zero(z),
    .array_ref_wire(w), .array_ref_m_wire(m), .segment(seg_i), .branch_taken(bt_i),
    .valid(v_i), .busy(b_i), .overrun(o_i));
  modulation_branch_select_pipe #(.WIDTH(32), .LATENCY(3), .PIPELINED(1), .INVERT(0)) dut_p (
    .clk(clk), .reset(reset), .start(start_p), .input_bit(ib), .zero(z),
    .array_ref_wire(w), .array_ref_m_wire(m), .segment(seg_p), .branch_taken(bt_p),
    .valid(v_p), .busy(b_p), .overrun(o_p));
  modulation_branch_select_pipe #(.WIDTH(32), .LATENCY(1), .PIPELINED(0), .INVERT(0)) dut_1 (
    .clk(clk), .reset(reset), .start(start_1), .input_bit(ib), .zero(z),
    .array_ref_wire(w), .array_ref_m_wire(m), .segment(seg_1), .branch_taken(bt_1),
    .valid(v_1), .busy(b_1), .overrun(o_1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ib, z, w, m;
    logic [31:0] seg_a;
    logic        bt_a;
    logic [31:0] seg_i;
    logic        bt_i;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h5,        32'h0,        32'hAAAA0001, 32'h00005555, 32'hAAAA0001, 1'b1, 32'h00005555, 1'b0};
    vecs[1] = '{32'h0,        32'h0,        32'hAAAA0001, 32'h12345678, 32'h12345678, 1'b0, 32'hAAAA0001, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'h22222222, 1'b0, 32'h11111111, 1'b1};
    vecs[3] = '{32'h80000000, 32'h0,        32'h33333333, 32'h44444444, 32'h33333333, 1'b1, 32'h44444444, 1'b0};
    vecs[4] = '{32'h1,        32'h2,        32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0};

    reset = 1'b1;
    start_a = 0; start_i = 0; start_p = 0; start_1 = 0;
    ib = 0; z = 0; w = 0; m = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_seg", seg_a, 32'h0);
    chk("reset_valid", {v_a, b_a, o_a, bt_a}, 32'h0);
    reset = 1'b0;

    // Table vectors on the L=2 single-issue and inverted instances
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ib = vecs[k].ib; z = vecs[k].z; w = vecs[k].w; m = vecs[k].m;
      start_a = 1; start_i = 1;
      @(negedge clk);
      start_a = 0; start_i = 0;
      chk($sformatf("v%0d_busy_e0", k), b_a, 1);
      @(negedge clk);
      chk($sformatf("v%0d_valid_e1", k), {v_a, v_i}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid_e2", k), {v_a, v_i}, 2'b11);
      chk($sformatf("v%0d_seg_a", k), seg_a, vecs[k].seg_a);
      chk($sformatf("v%0d_bt_a", k), bt_a, vecs[k].bt_a);
      chk($sformatf("v%0d_seg_i", k), seg_i, vecs[k].seg_i);
      chk($sformatf("v%0d_bt_i", k), bt_i, vecs[k].bt_i);
      chk($sformatf("v%0d_busy_e2", k), b_a, 0);
      @(negedge clk);
      chk($sformatf("v%0d_valid_pulse", k), v_a, 0);
    end

    // Overrun: second start in RUN dropped, start on completion edge accepted
    @(negedge clk);
    ib = 5; z = 0; w = 32'hAAAA0001; m = 32'h5555; start_a = 1;
    @(negedge clk);
    ib = 0; w = 32'h77777777; m = 32'h66666666;
    @(negedge clk);
    chk("ovr_set", o_a, 1);
    chk("ovr_no_valid_e1", v_a, 0);
    ib = 0; w = 32'h99999999; m = 32'h88888888;
    @(negedge clk);
    start_a = 0;
    chk("ovr_valid_e2", v_a, 1);
    chk("ovr_seg_e2", seg_a, 32'hAAAA0001);
    chk("ovr_busy_b2b", b_a, 1);
    @(negedge clk);
    chk("ovr_valid_e3", v_a, 0);
    chk("ovr_sticky", o_a, 1);
    @(negedge clk);
    chk("ovr_valid_e4", v_a, 1);
    chk("ovr_seg_e4", seg_a, 32'h88888888);
    chk("ovr_bt_e4", bt_a, 0);
    @(negedge clk);
    chk("ovr_single_pulse", v_a, 0);

    // Asynchronous reset in the middle of RUN
    ib = 5; w = 32'h12121212; start_a = 1;
    @(negedge clk);
    start_a = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_seg", seg_a, 32'h0);
    chk("arst_flags", {v_a, b_a, o_a, bt_a}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seen = seen | v_a;
      end
      chk("arst_no_valid", seen, 0);
    end

    // Pipelined L=3: starts at E0..E4 with alternating condition
    z = 0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        int e;
        e = k - 1;
        chk($sformatf("pipe_valid_e%0d", e), v_p, (e >= 3 && e <= 7) ? 1 : 0);
        chk($sformatf("pipe_busy_e%0d", e), b_p, (e <= 6) ? 1 : 0);
        if (e >= 3 && e <= 7) begin
          int j;
          j = e - 3;
          chk($sformatf("pipe_seg_e%0d", e), seg_p, (j % 2 == 0) ? 32'h100 + j : 32'h200 + j);
          chk($sformatf("pipe_bt_e%0d", e), bt_p, (j % 2 == 0) ? 1 : 0);
        end
      end
      start_p = (k <= 4);
      ib = (k % 2 == 0) ? 32'h1 : 32'h0;
      w = 32'h100 + k;
      m = 32'h200 + k;
    end
    start_p = 0;
    chk("pipe_overrun", o_p, 0);

    // Operand hold on L=2 and L=1; L=1 back-to-back on completion edge
    @(negedge clk);
    ib = 7; z = 7; w = 32'h0000000A; m = 32'h0000000B;
    start_a = 1; start_1 = 1;
    @(negedge clk);
    start_a = 0;
    ib = 1; w = 32'h0000000D; m = 32'h0000000C;
    chk("hold_l1_busy_e0", b_1, 1);
    chk("hold_l1_valid_e0", v_1, 0);
    @(negedge clk);
    start_1 = 0;
    chk("hold_l1_valid_e1", v_1, 1);
    chk("hold_l1_seg_e1", seg_1, 32'h0000000B);
    chk("hold_l1_bt_e1", bt_1, 0);
    chk("hold_l1_overrun", o_1, 0);
    @(negedge clk);
    chk("hold_l1_b2b_valid", v_1, 1);
    chk("hold_l1_b2b_seg", seg_1, 32'h0000000D);
    chk("hold_l1_b2b_bt", bt_1, 1);
    chk("hold_l2_valid", v_a, 1);
    chk("hold_l2_seg", seg_a, 32'h0000000B);
    @(negedge clk);
    chk("hold_l1_idle", {v_1, b_1}, 0);
    chk("hold_l2_segment_held", seg_a, 32'h0000000B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
